uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter wrapper.
- Recovers 8-bit frames from the serial line `rx_in`: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Oversamples the line at PRESCALE clocks per bit and samples each bit at mid-bit.
- Presents each good byte with a one-cycle valid strobe; reports parity and framing errors.

Parameters:
- PRESCALE, 8, clocks per serial bit; even, ≥4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line; idles high; asynchronous to clk.
- parity_en  input  1  1 = a parity bit follows the data bits.
- parity_type  input  1  0 = even parity, 1 = odd parity.
- data_out  output  DATA_WIDTH  last received byte.
- data_valid  output  1  one-cycle strobe: data_out holds a good frame.
- parity_error  output  1  one-cycle strobe: parity mismatch.
- stop_error  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset, synchronous and active-high:
  - data_out = 0; data_valid = parity_error = stop_error = busy = 0.
  - State goes to IDLE; synchronizer flops are set to 1.
- Input synchronization: `rx_in` passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- Bit counter: counts 0..PRESCALE-1, width $clog2(PRESCALE). Data bit counter: 0..DATA_WIDTH-1.
- States:
  - IDLE:
    - busy = 0.
    - On rx_s == 0 (armed only): go to START, clear the counter, set busy = 1.
    - Latch parity_en and parity_type here. Changes to them mid-frame are ignored.
  - START:
    - At counter == PRESCALE/2-1, sample the bit.
    - Sample 0: clear the counter, go to DATA.
    - Sample 1: treat as a glitch; go to IDLE, busy = 0, no strobes.
  - DATA:
    - Sample every PRESCALE cycles (counter == PRESCALE-1), so each sample falls at mid-bit.
    - Shift each bit into a shift register, LSB first.
    - After DATA_WIDTH bits, go to PARITY if latched parity_en = 1, else go to STOP.
  - PARITY:
    - Sample one bit.
    - Expected value = XOR of the data bits (even), or its inverse (odd).
    - Record a mismatch flag. Go to STOP.
  - STOP: sample one bit, then register the outputs on the next edge:
    - Stop bit = 1, no mismatch: data_out = shift register, data_valid = 1 for one cycle.
    - Stop bit = 1, mismatch: data_out updated, parity_error = 1 for one cycle, data_valid stays 0.
    - Stop bit = 0: stop_error = 1 for one cycle; data_valid and parity_error stay 0; data_out unchanged. Go to IDLE unarmed.
    - Otherwise go to IDLE armed.
- Arming:
  - IDLE accepts a start bit only after rx_s has been seen high at least once. This covers break conditions and reset mid-frame.
  - After stop_error or rst, the receiver stays idle until rx_in returns high.
- Latency:
  - Outputs assert at cycle 3 + PRESCALE/2 + N·PRESCALE after the clk edge where rx_in is first sampled low.
  - N = DATA_WIDTH+1 without parity, DATA_WIDTH+2 with parity.
  - At the defaults: 79 cycles without parity, 87 with parity.
- busy: falls in the same cycle the output strobe is asserted.
- Back-to-back frames: a start bit immediately after a valid stop bit must be received; at most one idle bit-time is needed.
- Reset mid-frame: the partial frame is discarded and no strobe is issued.
- Strobes are mutually exclusive; at most one is high in any cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every bit sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at counter values PRESCALE/2-2, PRESCALE/2-1, PRESCALE/2 of that bit.
  - The sample points shift accordingly; the latency above is unchanged.
  - A single-cycle glitch at mid-bit is rejected.
- Undefined: single sample of rx_s at the mid-bit point; majority logic is not instantiated.

Test Plan:
- Reset, then rx_in held high for 100 cycles → all outputs 0, busy 0, no strobes.
- PRESCALE=8, parity_en=0, frame 0xA5 → data_valid high for exactly 1 cycle, 79 cycles after the start edge; data_out=0xA5; busy high for the frame.
- parity_en=1, parity_type=1, frame 0xAA with parity bit 1 → data_valid, data_out=0xAA. Same frame with parity bit 0 → parity_error pulse, no data_valid, 87 cycles after the start edge.
- Frame 0x55, stop bit driven 0 then line held low 30 cycles, then frame 0x3C → stop_error pulse; no false start while low; 0x3C received normally.
- 2-cycle low pulse on idle rx_in → START rejects it, no strobes, busy returns to 0. With UART_RX_MAJORITY_EN, a 1-cycle inversion at mid-bit of data bit 3 → byte still correct.
- rst asserted during data bit 4, line still low → no strobe, outputs cleared. Then back-to-back frames 0x01, 0xFE sent after the line returns high → two data_valid pulses with correct data.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, receive-side counterpart of the UART transmitter
// wrapper. Recovers frames of the form: start bit, DATA_WIDTH data bits LSB
// first, optional parity bit, one stop bit. The line is oversampled at
// PRESCALE clocks per bit and each bit is sampled at mid-bit.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_in        serial line (idles high, asynchronous to clk)
//   parity_en    1 = a parity bit follows the data bits (latched while idle)
//   parity_type  0 = even, 1 = odd parity (latched while idle)
//   data_out     last good (or parity-failed) byte
//   data_valid   one-cycle strobe, data_out holds a good frame
//   parity_error one-cycle strobe, parity mismatch
//   stop_error   one-cycle strobe, stop bit sampled low
//   busy         high while a frame is in progress
//
// Build option: define UART_RX_MAJORITY_EN to replace the single mid-bit
// sample with a 2-of-3 majority vote around mid-bit.
module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

  state_e state_q, state_d;

  logic                  sync1_q, sync1_d;
  logic                  rx_s_q, rx_s_d;
  logic [1:0]            vld_q, vld_d;
  logic                  armed_q, armed_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_bit_q, stop_bit_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  busy_q, busy_d;

  logic sample;
  logic half_tick;
  logic bit_tick;

  assign half_tick = (cnt_q == HALF_M1);
  assign bit_tick  = (cnt_q == BIT_END);

`ifdef UART_RX_MAJORITY_EN
  // The first synchronizer stage already holds the value rx_s will take on
  // the next cycle, so voting over {rx_prev, rx_s, sync1} centres the window
  // on the nominal sample point without adding latency.
  logic rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) rx_prev_q <= 1'b1;
    else     rx_prev_q <= rx_s_q;
  end

  assign sample = (rx_prev_q & rx_s_q) | (rx_prev_q & sync1_q) | (rx_s_q & sync1_q);
`else
  assign sample = rx_s_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && !rx_s_q) state_d = START;
      START:   if (half_tick) state_d = sample ? IDLE : DATA;
      DATA:    if (bit_tick && bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_tick) state_d = STOP;
      STOP:    if (bit_tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. vld tracks when rx_s first carries a
  // real line sample after reset, so the reset value of the synchronizer
  // cannot arm the receiver while the line is held low.
  always_comb begin
    sync1_d        = rx_in;
    rx_s_d         = sync1_q;
    vld_d          = {vld_q[0], 1'b1};
    armed_d        = armed_q | (vld_q[1] & rx_s_q);
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_err_d      = par_err_q;
    stop_bit_d     = stop_bit_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        bit_d      = '0;
        par_err_d  = 1'b0;
        par_en_d   = parity_en;
        par_type_d = parity_type;
      end
      START: cnt_d = half_tick ? '0 : cnt_q + 1'b1;
      DATA: begin
        cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        if (bit_tick) begin
          shift_d = {sample, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + 1'b1;
        end
      end
      PARITY: begin
        cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        if (bit_tick) par_err_d = sample ^ (^shift_q) ^ par_type_q;
      end
      STOP: begin
        cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        if (bit_tick) stop_bit_d = sample;
      end
      DONE: begin
        if (stop_bit_q) begin
          data_out_d = shift_q;
          if (par_err_q) parity_error_d = 1'b1;
          else           data_valid_d   = 1'b1;
        end else begin
          // A low stop bit may be a break; wait for the line to go high.
          stop_error_d = 1'b1;
          armed_d      = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      vld_q          <= '0;
      armed_q        <= 1'b0;
      cnt_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_err_q      <= 1'b0;
      stop_bit_q     <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      rx_s_q         <= rx_s_d;
      vld_q          <= vld_d;
      armed_q        <= armed_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_err_q      <= par_err_d;
      stop_bit_q     <= stop_bit_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      busy_q         <= busy_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign busy         = busy_q;

endmodule
